shift_serdes: RTL

- Parametrised full-duplex shift engine: one parallel word in, serialised on sdo; one word sampled from sdi, delivered in parallel.
- Replaces ad-hoc fixed 8-bit serial-in/parallel-out and parallel-in/serial-out shifters.
- Adds:
  - valid/ready handshake
  - programmable bit period
  - selectable bit order
  - frame and bit-tick strobes
- Sits between bus-side register logic and serial pins (SPI-like links, LED chains, 74HC595/165 expanders).

---
 rtl/shift_serdes.sv | 132 +++++++++++++
 1 files changed

// File: rtl/shift_serdes.sv
// Full-duplex shift engine: parallel word out on sdo, word sampled from sdi returned in parallel.
// Optional even-parity bit appended and checked when SHIFT_SERDES_PARITY_EN is defined.
module shift_serdes #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [WIDTH-1:0]     tx_data,
  output logic                 rx_valid,
  output logic [WIDTH-1:0]     rx_data,
`ifdef SHIFT_SERDES_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 sdo,
  input  logic                 sdi,
  output logic                 frame,
  output logic                 bit_tick
);

`ifdef SHIFT_SERDES_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0]        LAST_BIT = CW'(NBITS - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [NBITS-1:0]     tx_shift;
  logic [NBITS-1:0]     rx_shift;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [CW-1:0]        bit_cnt;

  logic [NBITS-1:0]     tx_load;
  logic [NBITS-1:0]     tx_shifted;
  logic [NBITS-1:0]     rx_next;
  logic [WIDTH-1:0]     rx_word;
  logic                 first_bit;
  logic                 next_bit;

  always_comb begin
`ifdef SHIFT_SERDES_PARITY_EN
    // Parity travels last: it sits at the far end of the shift register from the first data bit.
    tx_load = LSB_FIRST ? {^tx_data, tx_data} : {tx_data, ^tx_data};
`else
    tx_load = tx_data;
`endif
    tx_shifted = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
    rx_next    = LSB_FIRST ? {sdi, rx_shift[NBITS-1:1]} : {rx_shift[NBITS-2:0], sdi};
    rx_word    = LSB_FIRST ? rx_next[WIDTH-1:0] : rx_next[NBITS-1 -: WIDTH];
    first_bit  = LSB_FIRST ? tx_load[0] : tx_load[NBITS-1];
    next_bit   = LSB_FIRST ? tx_shifted[0] : tx_shifted[NBITS-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      sdo      <= 1'b0;
      frame    <= 1'b0;
      bit_tick <= 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (tx_valid) begin
            state    <= SHIFT;
            tx_shift <= tx_load;
            div_q    <= clk_div;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sdo      <= first_bit;
            frame    <= 1'b1;
            tx_ready <= 1'b0;
            bit_tick <= (clk_div == '0);
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // bit_tick is kept equal to (div_cnt == div_q) one cycle ahead, so it doubles as the tick.
          if (bit_tick) begin
            tx_shift <= tx_shifted;
            rx_shift <= rx_next;
            div_cnt  <= '0;
            bit_cnt  <= bit_cnt + CNT_ONE;
            if (bit_cnt == LAST_BIT) begin
              state    <= DONE;
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              frame    <= 1'b0;
              tx_ready <= 1'b1;
              sdo      <= 1'b0;
              bit_tick <= 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
              parity_err <= ^rx_next;
`endif
            end else begin
              sdo      <= next_bit;
              bit_tick <= (div_q == '0);
            end
          end else begin
            div_cnt  <= div_cnt + DIV_ONE;
            bit_tick <= ((div_cnt + DIV_ONE) == div_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
